ram_sdp_be_init: RTL and testbench

//  Single-clock simple dual-port RAM (one write port, one read port) with
//  per-lane byte enables, selectable read-during-write behaviour, optional

---
 rtl/ram_sdp_be_init.sv | 127 ++++++++++++
 tb/tb_ram_sdp_be_init.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_be_init.sv
// Simple dual-port RAM with per-lane byte enables, selectable read-during-write
// behaviour, optional output register and a post-reset clear sequencer.
module ram_sdp_be_init #(
    parameter int unsigned         D_WIDTH    = 16,
    parameter int unsigned         A_WIDTH    = 5,
    parameter int unsigned         LANE_WIDTH = 8,
    parameter int unsigned         RDW_MODE   = 0,
    parameter int unsigned         OUT_REG    = 0,
    parameter logic [D_WIDTH-1:0]  CLEAR_VAL  = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             write_enable,
    input  logic [A_WIDTH-1:0]               address_write,
    input  logic [D_WIDTH-1:0]               data_write,
    input  logic [D_WIDTH/LANE_WIDTH-1:0]    byte_enable,
    input  logic                             read_enable,
    input  logic [A_WIDTH-1:0]               address_read,
    output logic [D_WIDTH-1:0]               data_read,
    output logic                             read_valid,
    output logic                             init_busy
);

    localparam int unsigned LANES = D_WIDTH / LANE_WIDTH;
    localparam int unsigned DEPTH = 2 ** A_WIDTH;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t               state, state_next;
    logic [A_WIDTH-1:0]   clr_addr, clr_addr_next;
    logic                 clear_write, port_write, port_read;

    logic [D_WIDTH-1:0]   mem [DEPTH];
    logic [D_WIDTH-1:0]   merged, rd_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        clear_write   = 1'b0;
        port_write    = 1'b0;
        port_read     = 1'b0;
        if (!reset) begin
            case (state)
                CLEAR: begin
                    clear_write   = 1'b1;
                    clr_addr_next = clr_addr + 1'b1;
                    if (&clr_addr)
                        state_next = IDLE;
                end
                IDLE: begin
                    port_write = write_enable;
                    port_read  = read_enable;
                end
            endcase
        end
    end

    assign init_busy = (state == CLEAR);

    // Whole-word write of the lane-merged value; disabled lanes keep their old bits.
    always_comb begin
        merged = mem[address_write];
        for (int unsigned i = 0; i < LANES; i++) begin
            if (byte_enable[i])
                merged[i*LANE_WIDTH +: LANE_WIDTH] = data_write[i*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    always_comb begin
        if (RDW_MODE != 0 && port_write && address_write == address_read)
            rd_word = merged;
        else
            rd_word = mem[address_read];
    end

    always_ff @(posedge clk) begin
        if (clear_write)
            mem[clr_addr] <= CLEAR_VAL;
        else if (port_write)
            mem[address_write] <= merged;
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [D_WIDTH-1:0] stage_data;
            logic               stage_valid;

            always_ff @(posedge clk) begin
                if (reset) begin
                    stage_data  <= '0;
                    stage_valid <= 1'b0;
                    data_read   <= '0;
                    read_valid  <= 1'b0;
                end else begin
                    stage_valid <= port_read;
                    if (port_read)
                        stage_data <= rd_word;
                    read_valid <= stage_valid;
                    if (stage_valid)
                        data_read <= stage_data;
                end
            end
        end else begin : g_direct
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_read  <= '0;
                    read_valid <= 1'b0;
                end else begin
                    read_valid <= port_read;
                    if (port_read)
                        data_read <= rd_word;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp_be_init.sv
// Directed bench: three instances (defaults, new-data RDW, output register)
// share one stimulus stream and are checked against hand-computed values.
module tb_ram_sdp_be_init;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_enable = 1'b0;
    logic [4:0]  address_write = '0;
    logic [15:0] data_write = '0;
    logic [1:0]  byte_enable = '0;
    logic        read_enable = 1'b0;
    logic [4:0]  address_read = '0;

    logic [15:0] data_read_0, data_read_n, data_read_r;
    logic        read_valid_0, read_valid_n, read_valid_r;
    logic        init_busy_0, init_busy_n, init_busy_r;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_sdp_be_init #(.D_WIDTH(16), .A_WIDTH(5), .LANE_WIDTH(8), .RDW_MODE(0), .OUT_REG(0)) dut (
        .clk(clk), .reset(reset), .write_enable(write_enable), .address_write(address_write),
        .data_write(data_write), .byte_enable(byte_enable), .read_enable(read_enable),
        .address_read(address_read), .data_read(data_read_0), .read_valid(read_valid_0),
        .init_busy(init_busy_0));

    ram_sdp_be_init #(.D_WIDTH(16), .A_WIDTH(5), .LANE_WIDTH(8), .RDW_MODE(1), .OUT_REG(0)) dut_n (
        .clk(clk), .reset(reset), .write_enable(write_enable), .address_write(address_write),
        .data_write(data_write), .byte_enable(byte_enable), .read_enable(read_enable),
        .address_read(address_read), .data_read(data_read_n), .read_valid(read_valid_n),
        .init_busy(init_busy_n));

    ram_sdp_be_init #(.D_WIDTH(16), .A_WIDTH(5), .LANE_WIDTH(8), .RDW_MODE(0), .OUT_REG(1)) dut_r (
        .clk(clk), .reset(reset), .write_enable(write_enable), .address_write(address_write),
        .data_write(data_write), .byte_enable(byte_enable), .read_enable(read_enable),
        .address_read(address_read), .data_read(data_read_r), .read_valid(read_valid_r),
        .init_busy(init_busy_r));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        step();
        check({tag, "_busy"}, {init_busy_0, init_busy_n, init_busy_r}, 3'b111);
        check({tag, "_valid"}, {read_valid_0, read_valid_n, read_valid_r}, 3'b000);
        check({tag, "_data0"}, data_read_0, 16'h0000);
        check({tag, "_datar"}, data_read_r, 16'h0000);
        reset = 1'b0;
    endtask

    // Counts edges until init_busy falls; read_valid must never rise meanwhile.
    task automatic init_wait(input string tag);
        int  n = 0;
        bit  leak = 1'b0;
        while (init_busy_0 && n < 100) begin
            step();
            n++;
            if (read_valid_0 || read_valid_n || read_valid_r)
                leak = 1'b1;
        end
        check({tag, "_busy_cycles"}, n, 32);
        check({tag, "_valid_leak"}, {31'b0, leak}, 0);
        check({tag, "_busy_all"}, {init_busy_0, init_busy_n, init_busy_r}, 3'b000);
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 34; i++) begin
            read_enable  = (i < 32);
            address_read = 5'(i);
            step();
            if (i < 32) begin
                check($sformatf("%s_d0_%0d", tag, i), {read_valid_0, data_read_0}, {1'b1, 16'h0000});
                check($sformatf("%s_dn_%0d", tag, i), {read_valid_n, data_read_n}, {1'b1, 16'h0000});
            end
            if (i == 0)
                check({tag, "_dr_lat"}, {31'b0, read_valid_r}, 0);
            else if (i <= 32)
                check($sformatf("%s_dr_%0d", tag, i - 1), {read_valid_r, data_read_r}, {1'b1, 16'h0000});
        end
        read_enable = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d, input logic [1:0] be);
        write_enable  = 1'b1;
        address_write = a;
        data_write    = d;
        byte_enable   = be;
        step();
        write_enable  = 1'b0;
    endtask

    // Single read: default/new-data instances answer after one edge, registered one after two.
    task automatic rd(input string tag, input logic [4:0] a,
                      input logic [15:0] e0, input logic [15:0] en, input logic [15:0] er);
        read_enable  = 1'b1;
        address_read = a;
        step();
        read_enable  = 1'b0;
        write_enable = 1'b0;
        check({tag, "_d0"}, {read_valid_0, data_read_0}, {1'b1, e0});
        check({tag, "_dn"}, {read_valid_n, data_read_n}, {1'b1, en});
        check({tag, "_dr_early"}, {31'b0, read_valid_r}, 0);
        step();
        check({tag, "_dr"}, {read_valid_r, data_read_r}, {1'b1, er});
        check({tag, "_d0_hold"}, {read_valid_0, data_read_0}, {1'b0, e0});
    endtask

    initial begin
        // Power-up clear and full-range readback
        do_reset("rst1");
        init_wait("init1");
        read_all_zero("zero1");

        // Full-word write then read
        wr(5'd3, 16'hA5C3, 2'b11);
        rd("wr_full", 5'd3, 16'hA5C3, 16'hA5C3, 16'hA5C3);

        // Low lane only
        wr(5'd3, 16'h1234, 2'b01);
        rd("wr_lane0", 5'd3, 16'hA534, 16'hA534, 16'hA534);

        // Read-during-write, same address, both lanes
        wr(5'd7, 16'h1111, 2'b11);
        write_enable = 1'b1; address_write = 5'd7; data_write = 16'h2222; byte_enable = 2'b11;
        rd("rdw_full", 5'd7, 16'h1111, 16'h2222, 16'h1111);

        // Read-during-write, same address, high lane only
        wr(5'd7, 16'h1111, 2'b11);
        write_enable = 1'b1; address_write = 5'd7; data_write = 16'h2222; byte_enable = 2'b10;
        rd("rdw_lane1", 5'd7, 16'h1111, 16'h2211, 16'h1111);
        rd("after_rdw", 5'd7, 16'h2211, 16'h2211, 16'h2211);

        // Read and write on different addresses are independent
        write_enable = 1'b1; address_write = 5'd8; data_write = 16'h5555; byte_enable = 2'b11;
        rd("diff_addr", 5'd7, 16'h2211, 16'h2211, 16'h2211);
        rd("diff_wr", 5'd8, 16'h5555, 16'h5555, 16'h5555);

        // Back-to-back reads through the pipeline
        wr(5'd0, 16'h000A, 2'b11);
        wr(5'd1, 16'h000B, 2'b11);
        wr(5'd2, 16'h000C, 2'b11);
        for (int k = 0; k < 5; k++) begin
            read_enable  = (k < 3);
            address_read = 5'(k);
            step();
            if (k < 3)
                check($sformatf("b2b_d0_%0d", k), {read_valid_0, data_read_0}, {1'b1, 16'h000A + 16'(k)});
            if (k == 0 || k == 4)
                check($sformatf("b2b_dr_idle_%0d", k), {31'b0, read_valid_r}, 0);
            else
                check($sformatf("b2b_dr_%0d", k), {read_valid_r, data_read_r}, {1'b1, 16'h000A + 16'(k - 1)});
        end
        check("b2b_dr_hold", data_read_r, 16'h000C);
        read_enable = 1'b0;

        // Byte enables all low: no change
        wr(5'd0, 16'hFFFF, 2'b00);
        rd("be_none", 5'd0, 16'h000A, 16'h000A, 16'h000A);

        // Reset partway through a clear with reads requested throughout
        read_enable  = 1'b1;
        address_read = 5'd3;
        do_reset("rst2");
        read_enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("midclr_%0d", c), {read_valid_0, read_valid_n, read_valid_r, init_busy_0}, 4'b0001);
        end
        do_reset("rst3");
        read_enable = 1'b1;
        init_wait("init3");
        read_all_zero("zero3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
